// File: rtl/pipe_stall_sched.sv
// Central stall/flush scheduler for the 5-stage pipeline: fixed-priority hazard resolution plus
// MDU countdown and memory-wait watchdog. Define PIPE_STALL_PERF_EN to build the stall_cycles counter.
module pipe_stall_sched #(
  parameter int CNT_W       = 4,
  parameter int MEM_TIMEOUT = 64,
  parameter int PERF_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lu_hazard,
  input  logic              br_taken,
  input  logic              mem_busy,
  input  logic              mdu_start,
  input  logic [CNT_W-1:0]  mdu_cycles,
  input  logic              exc_req,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              mem_wb_flush,
  output logic              pc_sel_exc,
  output logic              mdu_done,
  output logic              mdu_abort,
  output logic              bus_err,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_MDU_BUSY = 2'd2;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
    logic pc_sel_exc;
    logic mdu_done;
    logic mdu_abort;
    logic bus_err;
  } ctl_t;

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  mdu_cnt, mdu_cnt_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  ctl_t              ctl, ctl_out;
  logic              run_eval;

  function automatic ctl_t apply_exc(input ctl_t c);
    ctl_t r = c;
    r.if_id_flush  = 1'b1;
    r.id_ex_flush  = 1'b1;
    r.ex_mem_flush = 1'b1;
    r.pc_sel_exc   = 1'b1;
    return r;
  endfunction

  function automatic ctl_t freeze_mem(input ctl_t c);
    ctl_t r = c;
    r.pc_en        = 1'b0;
    r.if_id_en     = 1'b0;
    r.id_ex_en     = 1'b0;
    r.ex_mem_en    = 1'b0;
    r.mem_wb_flush = 1'b1;
    return r;
  endfunction

  // MDU freeze holds IF/ID/EX and lets MEM drain by loading a bubble into EX/MEM.
  function automatic ctl_t freeze_mdu(input ctl_t c);
    ctl_t r = c;
    r.pc_en        = 1'b0;
    r.if_id_en     = 1'b0;
    r.id_ex_en     = 1'b0;
    r.ex_mem_flush = 1'b1;
    return r;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ctl           = '0;
    ctl.pc_en     = 1'b1;
    ctl.if_id_en  = 1'b1;
    ctl.id_ex_en  = 1'b1;
    ctl.ex_mem_en = 1'b1;
    ctl.mem_wb_en = 1'b1;
    state_nxt     = state;
    mdu_cnt_nxt   = mdu_cnt;
    wait_cnt_nxt  = wait_cnt;
    run_eval      = 1'b0;

    case (state)
      ST_MEM_WAIT: begin
        if (mem_busy) begin
          // exc_req is deliberately ignored until the memory access completes.
          if (wait_cnt >= WAIT_W'(MEM_TIMEOUT)) begin
            ctl          = apply_exc(ctl);
            ctl.bus_err  = 1'b1;
            wait_cnt_nxt = '0;
            state_nxt    = ST_RUN;
          end else begin
            ctl          = freeze_mem(ctl);
            wait_cnt_nxt = wait_cnt + WAIT_W'(1);
          end
        end else begin
          wait_cnt_nxt = '0;
          run_eval     = 1'b1;
        end
      end
      ST_MDU_BUSY: begin
        if (exc_req) begin
          ctl           = apply_exc(ctl);
          ctl.mdu_abort = 1'b1;
          mdu_cnt_nxt   = '0;
          state_nxt     = ST_RUN;
        end else if (mdu_cnt > CNT_W'(1)) begin
          ctl         = freeze_mdu(ctl);
          mdu_cnt_nxt = mdu_cnt - CNT_W'(1);
        end else begin
          ctl.mdu_done = 1'b1;
          mdu_cnt_nxt  = '0;
          state_nxt    = ST_RUN;
        end
      end
      default: run_eval = 1'b1;
    endcase

    if (run_eval) begin
      state_nxt = ST_RUN;
      if (exc_req) begin
        ctl = apply_exc(ctl);
      end else if (mem_busy) begin
        ctl          = freeze_mem(ctl);
        wait_cnt_nxt = WAIT_W'(1);
        state_nxt    = ST_MEM_WAIT;
      end else if (mdu_start) begin
        if (mdu_cycles == '0) begin
          ctl.mdu_done = 1'b1;
        end else begin
          ctl         = freeze_mdu(ctl);
          mdu_cnt_nxt = mdu_cycles;
          state_nxt   = ST_MDU_BUSY;
        end
      end else if (lu_hazard) begin
        // Load-use outranks a taken branch: the branch stays in ID and resolves again next cycle.
        ctl.pc_en       = 1'b0;
        ctl.if_id_en    = 1'b0;
        ctl.id_ex_flush = 1'b1;
      end else if (br_taken) begin
        ctl.if_id_flush = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      mdu_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      mdu_cnt  <= mdu_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  assign ctl_out      = rst_n ? ctl : '0;
  assign pc_en        = ctl_out.pc_en;
  assign if_id_en     = ctl_out.if_id_en;
  assign id_ex_en     = ctl_out.id_ex_en;
  assign ex_mem_en    = ctl_out.ex_mem_en;
  assign mem_wb_en    = ctl_out.mem_wb_en;
  assign if_id_flush  = ctl_out.if_id_flush;
  assign id_ex_flush  = ctl_out.id_ex_flush;
  assign ex_mem_flush = ctl_out.ex_mem_flush;
  assign mem_wb_flush = ctl_out.mem_wb_flush;
  assign pc_sel_exc   = ctl_out.pc_sel_exc;
  assign mdu_done     = ctl_out.mdu_done;
  assign mdu_abort    = ctl_out.mdu_abort;
  assign bus_err      = ctl_out.bus_err;

`ifdef PIPE_STALL_PERF_EN
  logic [PERF_W-1:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (!ctl.pc_en && (stall_q != '1)) begin
      stall_q <= stall_q + PERF_W'(1);
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_sched.sv
// Directed self-checking bench for pipe_stall_sched; expected enable/flush/pulse vectors are hand-derived.
module tb_pipe_stall_sched;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 64;
  localparam int PERF_W      = 16;
`ifdef PIPE_STALL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Vector order: en = {pc,if_id,id_ex,ex_mem,mem_wb}, fl = {if_id,id_ex,ex_mem,mem_wb},
  // pu = {pc_sel_exc,mdu_done,mdu_abort,bus_err}.
  localparam logic [4:0] EN_ALL = 5'b11111;
  localparam logic [4:0] EN_LU  = 5'b00111;
  localparam logic [4:0] EN_MDU = 5'b00011;
  localparam logic [4:0] EN_MEM = 5'b00001;
  localparam logic [3:0] FL_NONE = 4'b0000;
  localparam logic [3:0] FL_EXC  = 4'b1110;
  localparam logic [3:0] FL_MEM  = 4'b0001;
  localparam logic [3:0] FL_MDU  = 4'b0010;
  localparam logic [3:0] FL_LU   = 4'b0100;
  localparam logic [3:0] FL_BR   = 4'b1000;
  localparam logic [3:0] PU_NONE  = 4'b0000;
  localparam logic [3:0] PU_EXC   = 4'b1000;
  localparam logic [3:0] PU_DONE  = 4'b0100;
  localparam logic [3:0] PU_ABORT = 4'b1010;
  localparam logic [3:0] PU_BUSER = 4'b1001;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             lu_hazard, br_taken, mem_busy, mdu_start, exc_req;
  logic [CNT_W-1:0] mdu_cycles;
  logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic             pc_sel_exc, mdu_done, mdu_abort, bus_err;
  logic [PERF_W-1:0] stall_cycles;

  logic [4:0] en_v;
  logic [3:0] fl_v, pu_v;

  int checks = 0;
  int failures = 0;
  int exp_stall = 0;

  pipe_stall_sched #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .lu_hazard(lu_hazard), .br_taken(br_taken), .mem_busy(mem_busy),
    .mdu_start(mdu_start), .mdu_cycles(mdu_cycles), .exc_req(exc_req),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .pc_sel_exc(pc_sel_exc), .mdu_done(mdu_done), .mdu_abort(mdu_abort), .bus_err(bus_err),
    .stall_cycles(stall_cycles)
  );

  assign en_v = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
  assign fl_v = {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
  assign pu_v = {pc_sel_exc, mdu_done, mdu_abort, bus_err};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [4:0] en, input logic [3:0] fl, input logic [3:0] pu);
    check({tag, ".en"}, 32'(en_v), 32'(en));
    check({tag, ".fl"}, 32'(fl_v), 32'(fl));
    check({tag, ".pu"}, 32'(pu_v), 32'(pu));
  endtask

  task automatic check_stall(input string tag);
    check({tag, ".stall"}, 32'(stall_cycles), PERF ? 32'(exp_stall) : 32'd0);
  endtask

  // Inputs change at posedge+1; outputs are sampled on the following negedge.
  task automatic cyc(input string tag, input logic [4:0] en, input logic [3:0] fl, input logic [3:0] pu);
    @(negedge clk);
    check_out(tag, en, fl, pu);
    if (!en[4]) exp_stall++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic lu, input logic br, input logic mb, input logic ms,
                        input logic [CNT_W-1:0] mc, input logic ex);
    lu_hazard  = lu;
    br_taken   = br;
    mem_busy   = mb;
    mdu_start  = ms;
    mdu_cycles = mc;
    exc_req    = ex;
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, '0, 0);
    @(negedge clk);
    check_out(tag, 5'b0, FL_NONE, PU_NONE);
    check({tag, ".stall"}, 32'(stall_cycles), 32'd0);
    #2;
    rst_n = 1'b1;
    exp_stall = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_in(0, 0, 0, 0, '0, 0);
    apply_reset("rst0");

    for (int i = 0; i < 5; i++) cyc("idle", EN_ALL, FL_NONE, PU_NONE);
    check_stall("idle");

    set_in(1, 1, 0, 0, '0, 0);
    cyc("lu_br", EN_LU, FL_LU, PU_NONE);
    set_in(0, 1, 0, 0, '0, 0);
    cyc("br_again", EN_ALL, FL_BR, PU_NONE);
    set_in(0, 0, 0, 0, '0, 0);
    cyc("post_br", EN_ALL, FL_NONE, PU_NONE);
    check_stall("lu");

    apply_reset("rst1");
    set_in(0, 0, 0, 1, 4'd3, 0);
    cyc("mdu3.c1", EN_MDU, FL_MDU, PU_NONE);
    set_in(0, 0, 0, 0, '0, 0);
    cyc("mdu3.c2", EN_MDU, FL_MDU, PU_NONE);
    set_in(1, 1, 1, 1, 4'd7, 0);
    cyc("mdu3.c3", EN_MDU, FL_MDU, PU_NONE);
    set_in(0, 0, 0, 0, '0, 0);
    cyc("mdu3.c4", EN_ALL, FL_NONE, PU_DONE);
    cyc("mdu3.after", EN_ALL, FL_NONE, PU_NONE);
    check_stall("mdu3");

    set_in(0, 0, 0, 1, 4'd0, 0);
    cyc("mdu0", EN_ALL, FL_NONE, PU_DONE);
    set_in(0, 0, 0, 0, '0, 0);
    cyc("mdu0.after", EN_ALL, FL_NONE, PU_NONE);

    set_in(0, 0, 0, 1, 4'd5, 0);
    cyc("mdu5.c1", EN_MDU, FL_MDU, PU_NONE);
    set_in(0, 0, 0, 0, '0, 0);
    cyc("mdu5.b1", EN_MDU, FL_MDU, PU_NONE);
    set_in(0, 0, 0, 0, '0, 1);
    cyc("mdu5.abort", EN_ALL, FL_EXC, PU_ABORT);
    set_in(0, 0, 0, 0, '0, 0);
    cyc("mdu5.after", EN_ALL, FL_NONE, PU_NONE);

    set_in(0, 0, 0, 0, '0, 1);
    cyc("exc_run", EN_ALL, FL_EXC, PU_EXC);

    apply_reset("rst2");
    set_in(0, 0, 1, 0, '0, 0);
    for (int c = 0; c < 70; c++) begin
      if (c == MEM_TIMEOUT) cyc($sformatf("mem.c%0d", c), EN_ALL, FL_EXC, PU_BUSER);
      else                  cyc($sformatf("mem.c%0d", c), EN_MEM, FL_MEM, PU_NONE);
    end
    set_in(0, 0, 0, 0, '0, 0);
    cyc("mem.release", EN_ALL, FL_NONE, PU_NONE);
    check_stall("mem");

    set_in(0, 0, 1, 0, '0, 0);
    cyc("memx.c1", EN_MEM, FL_MEM, PU_NONE);
    set_in(0, 0, 1, 0, '0, 1);
    cyc("memx.ignored", EN_MEM, FL_MEM, PU_NONE);
    set_in(0, 0, 0, 0, '0, 1);
    cyc("memx.honoured", EN_ALL, FL_EXC, PU_EXC);
    set_in(0, 0, 0, 0, '0, 0);
    cyc("memx.after", EN_ALL, FL_NONE, PU_NONE);

    set_in(0, 0, 0, 1, 4'd3, 0);
    cyc("rmid.c1", EN_MDU, FL_MDU, PU_NONE);
    set_in(0, 0, 0, 0, '0, 0);
    cyc("rmid.c2", EN_MDU, FL_MDU, PU_NONE);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_out("rmid.inrst", 5'b0, FL_NONE, PU_NONE);
    check("rmid.inrst.stall", 32'(stall_cycles), 32'd0);
    #2;
    rst_n = 1'b1;
    exp_stall = 0;
    @(posedge clk);
    #1;
    cyc("rmid.post", EN_ALL, FL_NONE, PU_NONE);
    cyc("rmid.post2", EN_ALL, FL_NONE, PU_NONE);
    check_stall("rmid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
